// File: rtl/emu_ram_scan_mr.sv
// emu_ram_scan_mr: DEPTH x DATA_WIDTH target RAM with NUM_RD registered read
// ports, one write port, and a CHAIN_WIDTH-bit checkpoint/restore scan chain.
// Optional feature macro: EMU_RAM_SCAN_OVERRUN_EN adds a sticky ram_err output
// and saturates the scan pointer at the chain end instead of wrapping to 0.
module emu_ram_scan_mr #(
  parameter int DATA_WIDTH  = 80,
  parameter int DEPTH       = 8,
  parameter int NUM_RD      = 2,
  parameter int CHAIN_WIDTH = 64
) (
  input  logic                                host_clk,
  input  logic                                rst,
  input  logic                                run_mode,
  input  logic                                scan_mode,
  input  logic [NUM_RD*$clog2(DEPTH)-1:0]     target_raddr,
  output logic [NUM_RD*DATA_WIDTH-1:0]        target_rdata,
  input  logic                                target_wen,
  input  logic [$clog2(DEPTH)-1:0]            target_waddr,
  input  logic [DATA_WIDTH-1:0]               target_wdata,
  input  logic                                ram_sr,
  input  logic                                ram_se,
  input  logic                                ram_sd,
  input  logic [CHAIN_WIDTH-1:0]              ram_di,
  output logic [CHAIN_WIDTH-1:0]              ram_do
`ifdef EMU_RAM_SCAN_OVERRUN_EN
  ,
  output logic                                ram_err
`endif
);

  localparam int AW     = $clog2(DEPTH);
  localparam int CHUNKS = (DATA_WIDTH + CHAIN_WIDTH - 1) / CHAIN_WIDTH;
  localparam int NE     = NUM_RD + DEPTH;
  localparam int EW     = $clog2(NE + 1);
  localparam int CIW    = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int PW     = CHUNKS * CHAIN_WIDTH;
  localparam logic [CIW-1:0] LAST_C = CIW'(CHUNKS - 1);
`ifndef EMU_RAM_SCAN_OVERRUN_EN
  localparam logic [EW-1:0]  LAST_E = EW'(NE - 1);
`endif

  typedef enum logic [1:0] {IDLE, PREFETCH, STREAM} state_t;
  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0]  mem     [DEPTH];
  logic [DATA_WIDTH-1:0]  rdata_q [NUM_RD];
  logic [EW-1:0]          ptr_e, nxt_e, fetch_e;
  logic [CIW-1:0]         ptr_c, nxt_c, fetch_c;
  logic [PW-1:0]          load_buf, assembled, fetch_padded;
  logic [DATA_WIDTH-1:0]  fetch_elem;
  logic [CHAIN_WIDTH-1:0] fetch_word;
  logic scan_ok, run_en, sr_hit, se_hit, dump_step, load_step, load_commit, at_end;

  // Pointer k is kept as (element, chunk) so no divider is needed.
  assign scan_ok     = scan_mode & ~run_mode;
  assign run_en      = run_mode & ~scan_mode;
  assign sr_hit      = scan_ok & ram_sr;
  assign se_hit      = scan_ok & ~ram_sr & ram_se &
                       (ram_sd ? (state != IDLE) : (state == STREAM));
  assign dump_step   = se_hit & ~ram_sd;
  assign load_step   = se_hit & ram_sd & ~at_end;
  assign load_commit = load_step & (ptr_c == LAST_C);
`ifdef EMU_RAM_SCAN_OVERRUN_EN
  assign at_end = (ptr_e == EW'(NE));
`else
  assign at_end = 1'b0;
`endif

  // Scan FSM state register.
  always_ff @(posedge host_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: a pointer reset always re-enters PREFETCH; losing scan access idles.
  always_comb begin
    state_nxt = state;
    if (!scan_ok)    state_nxt = IDLE;
    else if (ram_sr) state_nxt = PREFETCH;
    else begin
      case (state)
        IDLE:     state_nxt = PREFETCH;
        PREFETCH: state_nxt = STREAM;
        default:  state_nxt = STREAM;
      endcase
    end
  end

  // Pointer successor: chunks first, then elements; wrap or saturate at the end.
  always_comb begin
    nxt_e = ptr_e;
    nxt_c = ptr_c;
    if (!at_end) begin
      if (ptr_c == LAST_C) begin
        nxt_c = '0;
`ifdef EMU_RAM_SCAN_OVERRUN_EN
        nxt_e = ptr_e + EW'(1);
`else
        nxt_e = (ptr_e == LAST_E) ? '0 : ptr_e + EW'(1);
`endif
      end else begin
        nxt_c = ptr_c + CIW'(1);
      end
    end
  end

  // Select the chain word for ram_do: current word in PREFETCH, successor when streaming.
  always_comb begin
    fetch_e      = (state == STREAM) ? nxt_e : ptr_e;
    fetch_c      = (state == STREAM) ? nxt_c : ptr_c;
    fetch_elem   = '0;
    fetch_padded = '0;
    fetch_word   = '0;
    for (int i = 0; i < NUM_RD; i++)
      if (fetch_e == EW'(i)) fetch_elem = rdata_q[i];
    for (int j = 0; j < DEPTH; j++)
      if (fetch_e == EW'(NUM_RD + j)) fetch_elem = mem[j];
    fetch_padded[DATA_WIDTH-1:0] = fetch_elem;
    for (int i = 0; i < CHUNKS; i++)
      if (fetch_c == CIW'(i)) fetch_word = fetch_padded[i*CHAIN_WIDTH +: CHAIN_WIDTH];
  end

  // Merge the incoming load word into its chunk slot of the assembly buffer.
  always_comb begin
    assembled = load_buf;
    for (int i = 0; i < CHUNKS; i++)
      if (ptr_c == CIW'(i)) assembled[i*CHAIN_WIDTH +: CHAIN_WIDTH] = ram_di;
  end

  // Scan pointer update.
  always_ff @(posedge host_clk or posedge rst) begin
    if (rst) begin
      ptr_e <= '0;
      ptr_c <= '0;
    end else if (sr_hit) begin
      ptr_e <= '0;
      ptr_c <= '0;
    end else if (se_hit) begin
      ptr_e <= nxt_e;
      ptr_c <= nxt_c;
    end
  end

  // Dump output register: filled on prefetch, advanced on every consumed word.
  always_ff @(posedge host_clk or posedge rst) begin
    if (rst) ram_do <= '0;
    else if (scan_ok && !ram_sr && !ram_sd && (state == PREFETCH || dump_step))
      ram_do <= fetch_word;
  end

  // Load assembly buffer; partial elements are dropped when scan access ends.
  always_ff @(posedge host_clk or posedge rst) begin
    if (rst)                     load_buf <= '0;
    else if (!scan_ok || sr_hit) load_buf <= '0;
    else if (load_commit)        load_buf <= '0;
    else if (load_step)          load_buf <= assembled;
  end

  // Read-data registers: read-first target reads, or restore from the chain.
  always_ff @(posedge host_clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < NUM_RD; p++) rdata_q[p] <= '0;
    end else if (run_en) begin
      for (int p = 0; p < NUM_RD; p++) rdata_q[p] <= mem[target_raddr[p*AW +: AW]];
    end else if (load_commit) begin
      for (int p = 0; p < NUM_RD; p++)
        if (ptr_e == EW'(p)) rdata_q[p] <= assembled[DATA_WIDTH-1:0];
    end
  end

  // Memory array (not reset): target writes, or restore from the chain.
  always_ff @(posedge host_clk) begin
    if (run_en && target_wen) begin
      mem[target_waddr] <= target_wdata;
    end else if (load_commit) begin
      for (int j = 0; j < DEPTH; j++)
        if (ptr_e == EW'(NUM_RD + j)) mem[j] <= assembled[DATA_WIDTH-1:0];
    end
  end

  // Pack the read-data registers onto the output bus, port 0 in the LSBs.
  always_comb begin
    target_rdata = '0;
    for (int p = 0; p < NUM_RD; p++) target_rdata[p*DATA_WIDTH +: DATA_WIDTH] = rdata_q[p];
  end

`ifdef EMU_RAM_SCAN_OVERRUN_EN
  // Sticky overrun flag: a strobe past the last word, cleared only by ram_sr or rst.
  always_ff @(posedge host_clk or posedge rst) begin
    if (rst)                  ram_err <= 1'b0;
    else if (sr_hit)          ram_err <= 1'b0;
    else if (se_hit && at_end) ram_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_emu_ram_scan_mr.sv
// Self-checking bench for emu_ram_scan_mr (default parameters).
module tb_emu_ram_scan_mr;
  localparam int DW = 80, DEPTH = 8, NRD = 2, CW = 64, CHUNKS = 2, TOTAL = 20;

  logic host_clk = 1'b0;
  logic rst, run_mode, scan_mode, target_wen, ram_sr, ram_se, ram_sd;
  logic [NRD*3-1:0]  target_raddr;
  logic [NRD*DW-1:0] target_rdata;
  logic [2:0]        target_waddr;
  logic [DW-1:0]     target_wdata;
  logic [CW-1:0]     ram_di, ram_do;
`ifdef EMU_RAM_SCAN_OVERRUN_EN
  logic ram_err;
`endif

  emu_ram_scan_mr #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_RD(NRD), .CHAIN_WIDTH(CW)) dut (
    .host_clk(host_clk), .rst(rst), .run_mode(run_mode), .scan_mode(scan_mode),
    .target_raddr(target_raddr), .target_rdata(target_rdata), .target_wen(target_wen),
    .target_waddr(target_waddr), .target_wdata(target_wdata), .ram_sr(ram_sr),
    .ram_se(ram_se), .ram_sd(ram_sd), .ram_di(ram_di), .ram_do(ram_do)
`ifdef EMU_RAM_SCAN_OVERRUN_EN
    , .ram_err(ram_err)
`endif
  );

  always #5 host_clk = ~host_clk;

  typedef struct packed {
    logic          run;
    logic          wen;
    logic [2:0]    waddr;
    logic [DW-1:0] wdata;
    logic [2:0]    ra0;
    logic [2:0]    ra1;
    logic          chk;
    logic [DW-1:0] e0;
    logic [DW-1:0] e1;
  } vec_t;

  localparam logic [DW-1:0] BIG = 80'hFEDC_BA98_7654_3210_0F1E;

  vec_t tbl [14];
  logic [NRD*DW-1:0] rd_q   [$];
  logic [CW-1:0]     word_q [$];
  logic [DW-1:0]     m_mem  [DEPTH];
  logic [DW-1:0]     m_rd   [NRD];
  int checks = 0;
  int failures = 0;

  function automatic vec_t mkVec(input logic run, input logic wen, input int waddr,
                                 input logic [DW-1:0] wdata, input int ra0, input int ra1,
                                 input logic chk, input logic [DW-1:0] e0, input logic [DW-1:0] e1);
    vec_t v;
    v.run = run; v.wen = wen; v.waddr = 3'(waddr); v.wdata = wdata;
    v.ra0 = 3'(ra0); v.ra1 = 3'(ra1); v.chk = chk; v.e0 = e0; v.e1 = e1;
    return v;
  endfunction

  // Reference chain word k: element k/CHUNKS, chunk k%CHUNKS, zero padded.
  function automatic logic [CW-1:0] chainWord(input int k);
    int e, c;
    logic [DW-1:0] el;
    logic [CHUNKS*CW-1:0] pad;
    e = k / CHUNKS;
    c = k % CHUNKS;
    el = (e < NRD) ? m_rd[1'(e)] : m_mem[3'(e - NRD)];
    pad = '0;
    pad[DW-1:0] = el;
    return (c == 0) ? pad[CW-1:0] : pad[2*CW-1:CW];
  endfunction

  task automatic checkOutput(input string name, input logic [NRD*DW-1:0] act,
                             input logic [NRD*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    logic [NRD*DW-1:0] exp;
    scan_mode = 1'b0; ram_se = 1'b0; ram_sr = 1'b0;
    run_mode = v.run; target_wen = v.wen; target_waddr = v.waddr; target_wdata = v.wdata;
    target_raddr = {v.ra1, v.ra0};
    if (v.chk) rd_q.push_back({v.e1, v.e0});
    @(posedge host_clk);
    @(negedge host_clk);
    target_wen = 1'b0;
    if (v.run && v.wen) m_mem[v.waddr] = v.wdata;
    if (v.chk) begin
      exp = rd_q.pop_front();
      checkOutput("run_rdata", target_rdata, exp);
      m_rd[0] = v.e0;
      m_rd[1] = v.e1;
    end
  endtask

  task automatic scanReset(input logic sd);
    run_mode = 1'b0; scan_mode = 1'b1; ram_sd = sd; ram_se = 1'b0; ram_sr = 1'b1;
    @(posedge host_clk);
    @(negedge host_clk);
    ram_sr = 1'b0;
    @(posedge host_clk);
    @(posedge host_clk);
    @(negedge host_clk);
  endtask

  task automatic pushChain(input int n);
    for (int k = 0; k < n; k++) word_q.push_back(chainWord(k % TOTAL));
  endtask

  // Consume queued words, optionally with random ram_se backpressure.
  task automatic dumpWords(input logic bp);
    int cyc;
    logic se;
    logic [CW-1:0] exp;
    cyc = 0;
    while (word_q.size() > 0 && cyc < 400) begin
      se = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (se) begin
        exp = word_q.pop_front();
        checkOutput("dump_word", {{(NRD*DW-CW){1'b0}}, ram_do}, {{(NRD*DW-CW){1'b0}}, exp});
      end
      ram_se = se;
      @(posedge host_clk);
      @(negedge host_clk);
      cyc++;
    end
    ram_se = 1'b0;
    if (word_q.size() > 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL dump_timeout: got %0d words left expected 0", word_q.size());
      word_q.delete();
    end
  endtask

  task automatic loadChain(input logic bp);
    logic se;
    for (int k = 0; k < TOTAL; k++) begin
      ram_di = chainWord(k);
      do begin
        se = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
        ram_se = se;
        @(posedge host_clk);
        @(negedge host_clk);
      end while (!se);
    end
    ram_se = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [95:0] r;
    rst = 1'b1; run_mode = 1'b0; scan_mode = 1'b0; target_raddr = '0; target_wen = 1'b0;
    target_waddr = '0; target_wdata = '0; ram_sr = 1'b0; ram_se = 1'b0; ram_sd = 1'b0;
    ram_di = '0;
    repeat (2) @(negedge host_clk);
    checkOutput("reset_rdata", target_rdata, '0);
    checkOutput("reset_ram_do", {{(NRD*DW-CW){1'b0}}, ram_do}, '0);
`ifdef EMU_RAM_SCAN_OVERRUN_EN
    checkOutput("reset_ram_err", {{(NRD*DW-1){1'b0}}, ram_err}, '0);
`endif
    rst = 1'b0;
    @(negedge host_clk);

    // Test 1/2 plus run_mode gating, as a vector table
    for (int j = 0; j < 8; j++) tbl[j] = mkVec(1, 1, j, 80'(j) * 80'h1111, 0, 0, 0, '0, '0);
    tbl[8]  = mkVec(1, 0, 0, '0,          1, 6, 1, 80'h1111, 80'h6666);
    tbl[9]  = mkVec(1, 1, 3, 80'hABCD,    3, 3, 1, 80'h3333, 80'h3333);
    tbl[10] = mkVec(1, 0, 0, '0,          3, 7, 1, 80'hABCD, 80'h7777);
    tbl[11] = mkVec(1, 1, 0, BIG,         0, 2, 1, 80'h0,    80'h2222);
    tbl[12] = mkVec(0, 1, 5, 80'hDEAD,    5, 0, 1, 80'h0,    80'h2222);
    tbl[13] = mkVec(1, 0, 0, '0,          5, 0, 1, 80'h5555, BIG);
    for (int i = 0; i < 14; i++) applyStimulus(tbl[i]);

    // Test 3: dump with backpressure
    scanReset(1'b0);
    pushChain(TOTAL);
    dumpWords(1'b1);

    // Test 4: scramble memory, reload the saved chain, verify by redump and a read
    scan_mode = 1'b0; run_mode = 1'b1;
    for (int j = 0; j < DEPTH; j++) begin
      r = {$urandom(), $urandom(), $urandom()};
      target_wen = 1'b1; target_waddr = 3'(j); target_wdata = r[DW-1:0];
      @(posedge host_clk);
      @(negedge host_clk);
    end
    target_wen = 1'b0;
    run_mode = 1'b0;
    scanReset(1'b1);
    loadChain(1'b1);
    scanReset(1'b0);
    pushChain(TOTAL);
    dumpWords(1'b1);
    applyStimulus(mkVec(1, 0, 0, '0, 3, 0, 1, m_mem[3], m_mem[0]));

    // Test 5: reset mid-dump at k=7, then redump from word 0
    scanReset(1'b0);
    pushChain(7);
    dumpWords(1'b0);
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_rdata", target_rdata, '0);
    checkOutput("rst_mid_ram_do", {{(NRD*DW-CW){1'b0}}, ram_do}, '0);
    @(negedge host_clk);
    rst = 1'b0;
    m_rd[0] = '0;
    m_rd[1] = '0;
    scanReset(1'b0);
    pushChain(TOTAL);
    dumpWords(1'b1);

    // Test 6: strobe past the end of the chain
    scanReset(1'b0);
`ifdef EMU_RAM_SCAN_OVERRUN_EN
    pushChain(TOTAL);
    dumpWords(1'b0);
    checkOutput("end_ram_do", {{(NRD*DW-CW){1'b0}}, ram_do}, '0);
    checkOutput("end_ram_err", {{(NRD*DW-1){1'b0}}, ram_err}, '0);
    ram_se = 1'b1;
    @(posedge host_clk);
    @(negedge host_clk);
    ram_se = 1'b0;
    checkOutput("overrun_ram_err", {{(NRD*DW-1){1'b0}}, ram_err}, {{(NRD*DW-1){1'b0}}, 1'b1});
    ram_sr = 1'b1;
    @(posedge host_clk);
    @(negedge host_clk);
    ram_sr = 1'b0;
    checkOutput("sr_clears_ram_err", {{(NRD*DW-1){1'b0}}, ram_err}, '0);
`else
    pushChain(TOTAL + 1);
    dumpWords(1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/emu_ram_scan_mr.md
Name: emu_ram_scan_mr

Overview:
- Parametrised successor to the single-read/single-write scannable target RAM model.
- Provides DEPTH x DATA_WIDTH target memory with NUM_RD registered read ports and one write port.
- All memory words and read-data registers can be checkpointed (dumped) and restored over a CHAIN_WIDTH-bit RAM scan chain with host backpressure.
- Sits inside EMU_SYSTEM on host_clk, gated by run_mode/scan_mode.

Parameters:
DATA_WIDTH, 80, target word width
DEPTH, 8, number of target words (power of two, >= 2)
NUM_RD, 2, number of synchronous read ports (1..4)
CHAIN_WIDTH, 64, scan chain word width
Derived (not overridable):
- CHUNKS = ceil(DATA_WIDTH/CHAIN_WIDTH)
- TOTAL = (NUM_RD+DEPTH)*CHUNKS

Ports:
host_clk  in  1  host clock, all state on rising edge
rst  in  1  asynchronous active-high reset
run_mode  in  1  target clock enable
scan_mode  in  1  scan access enable
target_raddr  in  NUM_RD*log2(DEPTH)  packed read addresses, port 0 in LSBs
target_rdata  out  NUM_RD*DATA_WIDTH  packed registered read data
target_wen  in  1  write enable
target_waddr  in  log2(DEPTH)  write address
target_wdata  in  DATA_WIDTH  write data
ram_sr  in  1  scan pointer reset
ram_se  in  1  scan word transfer strobe
ram_sd  in  1  scan direction: 0 dump, 1 load
ram_di  in  CHAIN_WIDTH  scan load data
ram_do  out  CHAIN_WIDTH  scan dump data

Behaviour:
- Reset (rst=1, async): rdata registers=0, scan pointer=0, ram_do=0, load assembly buffer=0. Memory contents not reset.
- Run (run_mode=1, scan_mode=0):
  - Each edge: rdata[p] <= mem[raddr[p]] for every port p; 1-cycle latency.
  - If target_wen=1, mem[waddr] <= wdata.
  - Read-during-write to the same address returns OLD data (read-first).
- run_mode=0: rdata registers hold, writes ignored.
- Scan ops require scan_mode=1 and run_mode=0; otherwise ram_se/ram_sr are ignored.
- Chain order, element index e = 0..NUM_RD+DEPTH-1:
  - e<NUM_RD: rdata register e.
  - Else: mem[e-NUM_RD].
  - Each element is sent as CHUNKS words, LSB chunk first; the last chunk is zero-padded.
  - Word index k = e*CHUNKS + c.
- ram_sr=1: pointer k <= 0, load buffer cleared.
- Dump (ram_sd=0):
  - ram_do = word k, valid from the 2nd edge after ram_sr falls (memory prefetch).
  - An edge with ram_se=1 consumes word k; k increments and ram_do shows word k+1 from the next cycle.
  - ram_se may be deasserted for any number of cycles; ram_do and k hold meanwhile.
  - Consecutive ram_se=1 cycles stream one word per cycle with no bubbles.
- Load (ram_sd=1):
  - An edge with ram_se=1 latches ram_di into chunk c of the assembly buffer, then k increments.
  - On the edge latching c=CHUNKS-1, the assembled element is written to its rdata register or memory word.
  - ram_do is don't-care during load.
- Pointer end: after word TOTAL-1 the pointer wraps to 0 (see optional feature).
- Transitions: FSM states IDLE -> PREFETCH -> STREAM.
  - ram_sr forces PREFETCH.
  - Leaving scan_mode returns to IDLE without altering memory.
  - An incomplete load element (mid-chunk when scan_mode drops) is discarded.
- Switching ram_sd mid-chain without ram_sr: undefined; bench must not do it.

Optional Feature:
- Macro EMU_RAM_SCAN_OVERRUN_EN.
- When defined:
  - Adds output ram_err (1 bit, reset 0).
  - A ram_se edge with k==TOTAL sets ram_err sticky until ram_sr or rst; the pointer saturates at TOTAL.
  - Dump returns zeros past the end; load ignores data past the end.
- When undefined:
  - No ram_err port.
  - The pointer wraps to 0 and the chain restarts silently.

Test Plan:
1. Reset, write mem[j]=j*0x1111 for j=0..7, raddr0=1, raddr1=6 -> rdata0=0x1111, rdata1=0x6666 one cycle later.
2. Write and read address 3 in the same cycle (old 0x3333, new 0xABCD) -> rdata=0x3333, next read=0xABCD.
3. Dump with random ram_se backpressure -> TOTAL=20 words: rdata0 lo/hi, rdata1 lo/hi, then mem0..7 lo/hi; hi chunks upper 48 bits zero.
4. Dump, overwrite all memory with random data, then reload the saved chain with random backpressure -> every rdata and mem word matches the saved values bitwise.
5. Assert rst mid-dump at k=7, then ram_sr and redump -> stream restarts at word 0; memory unchanged.
6. With EMU_RAM_SCAN_OVERRUN_EN, issue 21 ram_se strobes -> ram_err=1 after the 21st, cleared by ram_sr. Without it, the 21st strobe returns word 0.
